// File: rtl/mbox_arb_pkg.sv
// Shared types and defaults for the mailbox transmit arbiter.
package mbox_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_t;

  localparam int MAX_WORDS_DEF   = 1024;
  localparam int TIMEOUT_CYC_DEF = 4096;
  localparam int BEAT_CNT_W      = 11;

  // Index width for a requester count; a single bit is kept even for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mbox_rr_pick.sv
// Combinational round-robin selector: the first requester after ptr wins.
module mbox_rr_pick
  import mbox_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // Scan ptr+1 .. ptr+NREQ so the previous owner is considered last.
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/mbox_tx_arb.sv
// Multi-requester mailbox transmit arbiter with packet framing and overrun guard.
// Optional stall timeout is built in when MBOX_ARB_TIMEOUT_EN is defined.
module mbox_tx_arb
  import mbox_arb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int MAX_WORDS   = MAX_WORDS_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic [NREQ*32-1:0] req_dat,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_abort,
  output logic [NREQ-1:0]   grant,
  output logic [31:0]       mbox_w_dat,
  output logic              mbox_w_valid,
  input  logic              mbox_w_ready,
  output logic              mbox_w_done,
  output logic              mbox_w_abort,
  output logic              err_overrun,
  output logic              err_timeout
);

  localparam int IW = idx_w(NREQ);

  // Handshake: a beat moves when mbox_w_valid && mbox_w_ready; the granted
  // requester sees the same transfer as req_valid[g] && req_ready[g].
  state_t                state, state_nxt;
  logic [NREQ-1:0]       grant_q, grant_nxt, pick_gnt;
  logic [IW-1:0]         gidx, gidx_nxt, ptr, ptr_nxt, pick_idx;
  logic [BEAT_CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic                  ovr_q, ovr_nxt;
  logic                  in_xfer, g_valid, g_last, g_abort, accept, stall_hit;
  logic [31:0]           g_dat;

  mbox_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    g_dat = '0;
    for (int i = 0; i < NREQ; i++)
      if (gidx == IW'(i)) g_dat = req_dat[32*i +: 32];
  end

  assign in_xfer   = (state == XFER);
  assign g_valid   = req_valid[gidx];
  assign g_last    = req_last[gidx];
  assign g_abort   = req_abort[gidx];

  // Owner abort masks the beat in the same cycle it is raised.
  assign mbox_w_valid = in_xfer & g_valid & ~g_abort;
  assign mbox_w_dat   = in_xfer ? g_dat : '0;
  assign req_ready    = (in_xfer & mbox_w_ready & ~g_abort) ? grant_q : '0;
  assign accept       = mbox_w_valid & mbox_w_ready;
  assign grant        = grant_q;
  assign mbox_w_done  = (state == DONE);
  assign mbox_w_abort = (state == ABORT);
  assign err_overrun  = ovr_q;

`ifdef MBOX_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYC + 1);
  logic [SW-1:0] stall_cnt;
  logic          stall;
  logic          tmo_q;

  assign stall       = mbox_w_valid & ~mbox_w_ready;
  assign stall_hit   = stall && (stall_cnt == SW'(TIMEOUT_CYC - 1));
  assign err_timeout = tmo_q;

  always_ff @(posedge aclk) begin
    if (reset) begin
      stall_cnt <= '0;
      tmo_q     <= 1'b0;
    end else begin
      stall_cnt <= stall ? stall_cnt + 1'b1 : '0;
      tmo_q     <= stall_hit;
    end
  end
`else
  assign stall_hit   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_q;
    gidx_nxt     = gidx;
    ptr_nxt      = ptr;
    beat_cnt_nxt = beat_cnt;
    ovr_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_nxt = pick_gnt;
          gidx_nxt  = pick_idx;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (g_abort) begin
          state_nxt = ABORT;
        end else if (accept) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          if (g_last) begin
            state_nxt = DONE;
          end else if (beat_cnt == BEAT_CNT_W'(MAX_WORDS - 1)) begin
            state_nxt = ABORT;
            ovr_nxt   = 1'b1;
          end
        end else if (stall_hit) begin
          state_nxt = ABORT;
        end
      end
      DONE, ABORT: begin
        grant_nxt    = '0;
        beat_cnt_nxt = '0;
        ptr_nxt      = gidx;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pointer resets to the top index so requester 0 is scanned first.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state    <= IDLE;
      grant_q  <= '0;
      gidx     <= '0;
      ptr      <= IW'(NREQ - 1);
      beat_cnt <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant_q  <= grant_nxt;
      gidx     <= gidx_nxt;
      ptr      <= ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
      ovr_q    <= ovr_nxt;
    end
  end

endmodule

// File: doc/mbox_tx_arb.md
MBOX_TX_ARB -- requirements
Module: mbox_tx_arb

Interface
REQ-001 Parameters SHALL be: NREQ, default 2, number of requesters (2..8); MAX_WORDS, default 1024, maximum beats per packet; TIMEOUT_CYC, default 4096, stall-timeout limit.
REQ-002 Ports SHALL be, in this order:
- aclk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_dat  in  NREQ*32  packet data; slice i is [32*i+31:32*i].
- req_valid  in  NREQ  beat valid.
- req_last  in  NREQ  final beat of the packet.
- req_ready  out  NREQ  beat accepted.
- req_abort  in  NREQ  requester cancels its packet.
- grant  out  NREQ  one-hot owner of the mailbox.
- mbox_w_dat  out  32  mailbox write data.
- mbox_w_valid  out  1  mailbox write valid.
- mbox_w_ready  in  1  mailbox write ready.
- mbox_w_done  out  1  packet-complete pulse.
- mbox_w_abort  out  1  packet-abort pulse.
- err_overrun  out  1  pulse; packet exceeded MAX_WORDS.
- err_timeout  out  1  pulse; stall timeout.

Function
REQ-003 The FSM SHALL have the states IDLE, XFER, DONE and ABORT.
REQ-004 IDLE: if any req_valid is high, the block SHALL pick one requester round-robin, starting from the index after the last owner, register grant, and enter XFER on the next cycle.
REQ-005 IDLE with no req_valid SHALL hold all outputs at 0.
REQ-006 XFER: mbox_w_valid SHALL equal req_valid[g], mbox_w_dat SHALL equal the slice for g, req_ready[g] SHALL equal mbox_w_ready, and every other req_ready SHALL be 0; g is the granted index.
REQ-007 A beat SHALL be accepted when mbox_w_valid and mbox_w_ready are both high, and each accepted beat SHALL increment an 11-bit beat counter.
REQ-008 An accepted beat with req_last[g] high SHALL move the FSM to DONE.
REQ-009 An accepted beat that brings the count to MAX_WORDS without req_last SHALL move the FSM to ABORT and pulse err_overrun for 1 cycle. A last beat arriving exactly at MAX_WORDS is legal.
REQ-010 req_abort[g] in XFER SHALL take priority over any beat: in that cycle req_ready and mbox_w_valid SHALL be forced to 0 and the FSM SHALL go to ABORT.
REQ-011 req_abort of a non-granted requester SHALL be ignored.
REQ-012 DONE SHALL drive mbox_w_done=1 for exactly 1 cycle, clear grant, reset the beat counter, and return to IDLE.
REQ-013 ABORT SHALL drive mbox_w_abort=1 for exactly 1 cycle, clear grant, reset the beat counter, and return to IDLE.
REQ-014 The round-robin pointer SHALL advance to the owner index on both DONE and ABORT.
REQ-015 Because of the DONE/ABORT cycle plus the arbitration cycle, back-to-back packets SHALL have a gap of at least 2 cycles on mbox_w_valid.
REQ-016 mbox_w_done and mbox_w_abort SHALL never be high in the same cycle.

Reset
REQ-017 While reset is high at a rising edge of aclk, the block SHALL reach the following state: FSM in IDLE; grant, counters and all pulses at 0; round-robin pointer set so that requester 0 has highest priority.
REQ-018 Reset during XFER SHALL drop mbox_w_valid on the next cycle and SHALL NOT emit mbox_w_done or mbox_w_abort.

Configuration
REQ-019 With MBOX_ARB_TIMEOUT_EN defined, a stall counter SHALL count consecutive XFER cycles in which mbox_w_valid is high and mbox_w_ready is low, and SHALL clear on any accepted beat.
REQ-020 With MBOX_ARB_TIMEOUT_EN defined, a stall count reaching TIMEOUT_CYC SHALL move the FSM to ABORT and pulse err_timeout for 1 cycle.
REQ-021 Without MBOX_ARB_TIMEOUT_EN, the stall counter SHALL be absent, err_timeout SHALL be tied to 0, and stalls SHALL be unbounded.

Structure
REQ-022 Package mbox_arb_pkg SHALL hold the state enum and the default values of MAX_WORDS and TIMEOUT_CYC.
REQ-023 Sub-module mbox_rr_pick SHALL hold the combinational round-robin selector: inputs are the request vector and the pointer; outputs are the one-hot grant and its index.

Verification
REQ-024 Req0 sends 4 beats (0x11..0x14, last on the 4th) with ready always high -> 4 mbox_w beats in order, mbox_w_done 1 cycle after the 4th beat, grant=0x1 during the transfer.
REQ-025 Req0 and req1 both valid in IDLE after reset -> req0 served first, then req1. On the next contention -> req1 is skipped and req0 is chosen only after req1 has had its turn.
REQ-026 MAX_WORDS=4 and req0 sends 5 beats without last -> 4 beats accepted, then err_overrun and mbox_w_abort pulses, and req_ready stays 0 for the 5th beat.
REQ-027 req_abort[0] asserted on the 2nd beat while valid and ready are high -> that beat is not accepted, mbox_w_abort pulses, and the next requester is granted.
REQ-028 With MBOX_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, mbox_w_ready is held low -> err_timeout and mbox_w_abort pulse after 8 stalled cycles. The same test without the macro -> the bench waits indefinitely, with no abort.
REQ-029 reset is pulsed in the middle of beat 2 -> outputs return to 0 on the next cycle, no done or abort pulse appears, and requester 0 has priority afterwards.
